// File: rtl/iec_sd_arbiter_pkg.sv
// Shared drive-side types for the IEC drive SD plumbing.
// Arbiter FSM states and drive-count clamping.
package iec_drive_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } sd_arb_state_t;

  localparam int MAX_DRIVES = 8;

  function automatic int clamp_ndr(int n);
    if (n < 1) return 1;
    if (n > MAX_DRIVES) return MAX_DRIVES;
    return n;
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// Host-side SD request channel shared by all drives.
// master = arbiter, slave = hps_io side.
interface iec_sd_arbiter_if #(
  parameter int BLKW = 6
);
  logic [31:0]     lba;
  logic [BLKW-1:0] blk_cnt;
  logic            rd;
  logic            wr;
  logic            ack;
  logic [7:0]      buff_din;

  modport master (
    output lba,
    output blk_cnt,
    output rd,
    output wr,
    output buff_din,
    input  ack
  );

  modport slave (
    input  lba,
    input  blk_cnt,
    input  rd,
    input  wr,
    input  buff_din,
    output ack
  );
endinterface

// File: rtl/iec_rr_pick.sv
// Round-robin picker: first requester at or after ptr, modulo NDR.
// Rotate by ptr, priority-encode, then un-rotate.
module iec_rr_pick #(
  parameter int NDR = 4
) (
  input  logic [NDR-1:0] req,
  input  logic [2:0]     ptr,
  output logic [2:0]     idx,
  output logic           any
);

  logic [NDR-1:0] rot;
  logic [2:0]     off;

  function automatic int wrap(int v);
    return (v >= NDR) ? v - NDR : v;
  endfunction

  always_comb begin
    rot = '0;
    for (int k = 0; k < NDR; k++) begin
      for (int j = 0; j < NDR; j++) begin
        if (wrap(int'(ptr) + k) == j) rot[k] = req[j];
      end
    end
  end

  always_comb begin
    off = '0;
    for (int k = NDR - 1; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
  end

  assign idx = 3'(wrap(int'(ptr) + int'(off)));
  assign any = |req;

endmodule

// File: rtl/iec_sd_arbiter.sv
// Merges up to 8 drive SD request channels onto one host SD channel.
// Round-robin grant, read-over-write, per-request timeout, ack steering.
module iec_sd_arbiter
  import iec_drive_pkg::*;
#(
  parameter int          DRIVES  = 4,
  parameter int          BLKW    = 6,
  parameter logic [23:0] TIMEOUT = 24'd8000000,
  localparam int         NDR     = clamp_ndr(DRIVES)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [31:0]     drv_lba     [NDR],
  input  logic [BLKW-1:0] drv_blk_cnt [NDR],
  input  logic [NDR-1:0]  drv_rd,
  input  logic [NDR-1:0]  drv_wr,
  output logic [NDR-1:0]  drv_ack,
  input  logic [7:0]      drv_buff_din [NDR],
  iec_sd_arbiter_if.master sd,
  output logic [2:0]      grant,
  output logic            busy,
  output logic [NDR-1:0]  err_timeout
);

  localparam logic [23:0] TLAST = TIMEOUT - 24'd1;

  sd_arb_state_t   state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      rr_q, rr_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [31:0]     lba_q, lba_d;
  logic [BLKW-1:0] blk_q, blk_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [NDR-1:0]  err_q, err_d;

  logic [2:0]      pick_idx;
  logic            pick_any;
  logic [NDR-1:0]  pick_oh;
  logic [NDR-1:0]  grant_oh;
  logic [31:0]     sel_lba;
  logic [BLKW-1:0] sel_blk;
  logic            sel_rd;
  logic            sel_wr;
  logic [7:0]      sel_buff;

  iec_rr_pick #(
    .NDR (NDR)
  ) u_pick (
    .req (drv_rd | drv_wr),
    .ptr (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    sel_lba  = '0;
    sel_blk  = '0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_buff = '0;
    for (int i = 0; i < NDR; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_oh[i] = 1'b1;
        sel_lba    = drv_lba[i];
        sel_blk    = drv_blk_cnt[i];
        sel_rd     = drv_rd[i];
        sel_wr     = drv_wr[i];
      end
      if (grant_q == 3'(i)) begin
        grant_oh[i] = 1'b1;
        sel_buff    = drv_buff_din[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          lba_d   = sel_lba;
          blk_d   = sel_blk;
          rd_d    = sel_rd;
          wr_d    = sel_wr & ~sel_rd;
          err_d   = err_q & ~pick_oh;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over a timeout landing on the same cycle.
        if (sd.ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (TIMEOUT != 24'd0 && cnt_q == TLAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = err_q | grant_oh;
          state_d = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        if (!sd.ack) state_d = DONE;
      end
      DONE: begin
        if (grant_q == 3'(NDR - 1)) rr_d = '0;
        else rr_d = grant_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      lba_q   <= '0;
      blk_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign sd.lba      = lba_q;
  assign sd.blk_cnt  = blk_q;
  assign sd.rd       = rd_q;
  assign sd.wr       = wr_q;
  assign sd.buff_din = sel_buff;

  assign drv_ack     = (sd.ack && (state_q == REQ || state_q == XFER))
                       ? grant_oh : '0;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: doc/iec_sd_arbiter.md
Name: iec_sd_arbiter

Overview:
- Parametrised successor to the per-drive SD plumbing in the drive selector.
- Merges the SD-card request channels of up to 8 emulated drives onto one host SD channel, so any number of drives share a single sd_lba/sd_rd/sd_wr/sd_ack port.
- Provides round-robin fairness, read-over-write priority, request timeout with an error flag, and per-drive ack steering.
- Sits between the c1541/c1581 multi-drive blocks and the hps_io SD interface, entirely in the clk_sys domain.

Parameters:
DRIVES, 4, number of drive channels; clamped internally to NDR = 1..8, N = NDR-1
BLKW, 6, width of block-count field
TIMEOUT, 24'd8000000, clk_sys cycles allowed between sd_rd/sd_wr rising and sd_ack rising; 0 disables the timeout

Ports:
clk_sys  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high
drv_lba[NDR]  in  32  per-drive requested LBA
drv_blk_cnt[NDR]  in  BLKW  per-drive block count minus one
drv_rd  in  NDR  per-drive read request, level, held until ack
drv_wr  in  NDR  per-drive write request, level, held until ack
drv_ack  out  NDR  per-drive ack, sd_ack steered to the granted drive
drv_buff_din[NDR]  in  8  per-drive write data
sd_lba  out  32  host LBA, registered
sd_blk_cnt  out  BLKW  host block count, registered
sd_rd  out  1  host read request, registered
sd_wr  out  1  host write request, registered
sd_ack  in  1  host ack, high for the whole transfer
sd_buff_din  out  8  write data muxed from the granted drive
grant  out  3  index of the current or last granted drive
busy  out  1  high in any state other than IDLE
err_timeout  out  NDR  sticky per-drive timeout flag; bit cleared when that drive's request is next granted

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, drv_ack=0, grant=0, busy=0, err_timeout=0, state=IDLE, rr pointer=0, timeout counter=0.
- FSM states:
  - IDLE: req[i] = drv_rd[i] | drv_wr[i]. If any req, pick the first i at or after (rr pointer) modulo NDR. Latch grant=i, sd_lba=drv_lba[i], sd_blk_cnt=drv_blk_cnt[i]. Set sd_rd=drv_rd[i]; set sd_wr=drv_wr[i] & ~drv_rd[i] (read wins when both are set). Clear err_timeout[i] and the counter. Go to REQ.
  - REQ: hold outputs and count cycles.
    - On sd_ack=1: drop sd_rd/sd_wr, go to XFER.
    - When the counter reaches TIMEOUT-1 with TIMEOUT≠0: drop sd_rd/sd_wr, set err_timeout[grant], go to DONE.
  - XFER: wait for sd_ack=0, then go to DONE.
  - DONE: one cycle. Set rr pointer = grant+1 (wraps to 0 after N). Go to IDLE.
- Latency: a request present at clock edge t in IDLE gives sd_rd/sd_wr high after edge t. Minimum request-to-request spacing is 3 cycles after sd_ack falls (XFER→DONE→IDLE→REQ).
- drv_ack[i] = sd_ack & (grant==i) & (state==REQ|XFER). This is combinational from sd_ack, so the drive sees ack in the same cycle as the host.
- sd_buff_din = drv_buff_din[grant], combinational. It is valid in every state.
- sd_ack high while in IDLE or DONE is ignored; drv_ack stays 0.
- A drive that drops its request during REQ does not abort the cycle. The host transaction completes and the ack is still steered to that drive.
- A drive that keeps its request high after ack is re-arbitrated normally. No re-grant happens while other drives are pending (round robin).
- Requests arriving during REQ, XFER or DONE wait for IDLE.
- Reset mid-transfer returns everything to reset values at the next edge. The host sees sd_rd/sd_wr fall; drv_ack goes 0 immediately because state becomes IDLE.
- NDR=1: the rr pointer is constant 0. The grant index width stays 3, with the upper bits 0.
- Timeout counter width is 24 bits. It saturates and does not wrap.

Decomposition:
- Package iec_drive_pkg holds:
  - enum sd_arb_state_t {IDLE, REQ, XFER, DONE};
  - localparam MAX_DRIVES=8;
  - function clamp_ndr(int) shared with the drive selector.
- Sub-module iec_rr_pick: purely combinational. Inputs are req[NDR] and ptr[2:0]. Outputs are idx[2:0] and any.
  - It rotates by ptr, applies a priority encoder, then un-rotates.

Test Plan:
- Single read: DRIVES=4, drv_rd[2]=1, drv_lba[2]=32'h0000_0165 → next cycle sd_rd=1, sd_lba=0x165, grant=2. Host acks for 10 cycles → drv_ack=4'b0100 for 10 cycles; busy falls 2 cycles after sd_ack falls.
- Round robin: drv_rd=4'b1011 held; each ack 5 cycles → grant order 0,1,3,0,1. Drive 2 is never granted.
- Read/write same drive: drv_rd[1]=drv_wr[1]=1 → sd_rd=1, sd_wr=0. After completion, with drv_wr[1] only → sd_wr=1 and sd_buff_din tracks drv_buff_din[1] (0xA5).
- Timeout: TIMEOUT=16, drv_wr[3]=1, no sd_ack → sd_wr falls after 16 cycles, err_timeout=4'b1000. Re-request from drive 3 with ack → err_timeout clears at grant.
- Reset mid-XFER: reset pulsed while sd_ack=1 → sd_rd/sd_wr/drv_ack=0 and state IDLE on the next edge; late sd_ack is ignored.
- Spurious ack: sd_ack=1 in IDLE with no requests → drv_ack=0 and busy=0.
